channel_rr_arbiter: RTL

- M-input, one-output arbiter for valid/data-acknowledge channels. Shares one downstream Channel among M upstream requesters, for example several router outputs feeding one serializer.
- Arbitration is round-robin with burst locking: a granted input keeps the grant for up to MaxBurst consecutive transfers, or until its packet tail when TailBit is enabled.
- The output is registered: one pipeline stage, full throughput, no bubbles.

---
 rtl/channel_rr_arbiter_pkg.sv | 37 +++
 rtl/channel_rr_arbiter_if.sv | 18 +
 rtl/channel_rr_arbiter_picker.sv | 26 ++
 rtl/channel_rr_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/channel_rr_arbiter_pkg.sv
// Shared types and helpers for the channel round-robin arbiter.
// rr_next is usable by any arbiter needing a cyclic priority scan.
package channel_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  localparam int MAX_M = 16;
  localparam int IDX_W = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Never returns 0 so single-entry vectors still get a 1-bit index.
  function automatic int clog2_safe(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic rr_pick_t rr_next(input logic [MAX_M-1:0] valid_vec,
                                       input logic [IDX_W-1:0] last,
                                       input int               m);
    rr_pick_t pick;
    int       cand;
    pick = '0;
    for (int k = 1; k <= MAX_M; k++) begin
      cand = int'(last) + k;
      if (cand >= m) cand = cand - m;
      if (k <= m && !pick.found && valid_vec[cand[IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/channel_rr_arbiter_if.sv
// Valid/data-acknowledge channel, single and M-wide bundle.
interface channel_if #(parameter int N = 8);
  logic [N-1:0] d;
  logic         v;
  logic         a;

  modport master (output d, output v, input a);
  modport slave  (input d, input v, output a);
endinterface

interface channel_array_if #(parameter int N = 8, parameter int M = 4);
  logic [M-1:0][N-1:0] d;
  logic [M-1:0]        v;
  logic [M-1:0]        a;

  modport master (output d, output v, input a);
  modport slave  (input d, input v, output a);
endinterface

// File: rtl/channel_rr_arbiter_picker.sv
// Combinational cyclic-priority encoder: first valid input after last_grant.
module rr_priority_picker
  import channel_arb_pkg::*;
#(
  parameter int M = 4
) (
  input  logic [M-1:0]               v,
  input  logic [clog2_safe(M)-1:0]   last_grant,
  output logic [clog2_safe(M)-1:0]   grant,
  output logic                       found
);

  localparam int LW = clog2_safe(M);

  logic [MAX_M-1:0] v_ext;
  rr_pick_t         pick;

  always_comb begin
    v_ext        = '0;
    v_ext[M-1:0] = v;
    pick         = rr_next(v_ext, IDX_W'(last_grant), M);
    grant        = LW'(pick.idx);
    found        = pick.found;
  end

endmodule

// File: rtl/channel_rr_arbiter.sv
// M-to-1 round-robin channel arbiter with burst/packet locking and a
// registered output stage that sustains one transfer per cycle.
module channel_rr_arbiter
  import channel_arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int MaxBurst = 2,
  parameter int TailBit  = -1
) (
  input logic            clk,
  input logic            reset,
  channel_array_if.slave in,
  channel_if.master      out
);
  // state  | meaning
  // IDLE   | no lock; grant follows the round-robin scan
  // LOCKED | last_grant owns the output until burst limit or packet tail

  localparam int              LW       = clog2_safe(M);
  localparam int              CW       = clog2_safe(MaxBurst + 1);
  localparam bit              PKT_MODE = (TailBit >= 0);
  localparam int              TAIL_IDX = PKT_MODE ? TailBit : 0;
  localparam logic [CW-1:0]   CT_MAX   = CW'(MaxBurst);
  localparam logic [LW-1:0]   LG_RESET = LW'(M - 1);

  if (MaxBurst < 1) begin : g_chk_burst
    $error("channel_rr_arbiter: MaxBurst must be at least 1");
  end
  if (TailBit < -1 || TailBit >= N) begin : g_chk_tail
    $error("channel_rr_arbiter: TailBit must lie in -1..N-1");
  end
  if (M < 1 || M > MAX_M) begin : g_chk_m
    $error("channel_rr_arbiter: M must lie in 1..16");
  end

  arb_state_t    state, state_nxt;
  logic [LW-1:0] last_grant, last_grant_nxt;
  logic [LW-1:0] pick_grant, grant;
  logic [CW-1:0] burst_ct, burst_ct_nxt, ct_inc;
  logic          pick_found, hold, gvalid, load, xfer, tail, ends_burst;

  rr_priority_picker #(.M(M)) u_picker (
    .v          (in.v),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .found      (pick_found)
  );

  // In burst mode a lock whose owner drops v is abandoned at once;
  // in packet mode it is held so packets stay contiguous.
  always_comb begin
    hold       = (state == LOCKED) && (PKT_MODE || in.v[last_grant]);
    grant      = hold ? last_grant : pick_grant;
    gvalid     = hold ? in.v[last_grant] : pick_found;
    load       = ~out.v | out.a;
    xfer       = load & gvalid & ~reset;
    tail       = PKT_MODE && in.d[grant][TAIL_IDX];
    ct_inc     = hold ? burst_ct + CW'(1) : CW'(1);
    ends_burst = (ct_inc == CT_MAX) || tail;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= LG_RESET;
      burst_ct   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_ct   <= burst_ct_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_ct_nxt   = burst_ct;
    if (xfer) begin
      last_grant_nxt = grant;
      if (ends_burst) begin
        state_nxt    = IDLE;
        burst_ct_nxt = '0;
      end else begin
        state_nxt    = LOCKED;
        burst_ct_nxt = ct_inc;
      end
    end else if (load && state == LOCKED && !hold) begin
      state_nxt    = IDLE;
      burst_ct_nxt = '0;
    end
  end

  always_comb begin
    in.a = '0;
    if (xfer) in.a[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out.v <= 1'b0;
      out.d <= '0;
    end else if (xfer) begin
      out.v <= 1'b1;
      out.d <= in.d[grant];
    end else if (out.a) begin
      out.v <= 1'b0;
    end
  end

endmodule
